ctr_mod_updown: RTL and testbench
=================================

Name: ctr_mod_updown

Overview:
- Parametrised successor of the free-running 2-bit counter.
- Modulo-N up/down counter with an integrated clock-enable prescaler, synchronous clear, parallel load, and a wrap/saturate mode.
- Emits a registered terminal-count pulse, so instances cascade into multi-digit counters (e.g. BCD display digits, LED sequencers) that all run on the single system clock.

Parameters:
- WIDTH, 4: counter width in bits; requires MODULUS <= 2**WIDTH.
- MODULUS, 10: count range is 0..MODULUS-1; requires MODULUS >= 2.
- PRESCALE, 1: number of enabled clk cycles per count step; requires PRESCALE >= 1. A value of 1 means step on every enabled cycle.
- SATURATE, 0: 0 = wrap at the ends; 1 = hold at the ends.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; also gates the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  registered counter value.
- tc  out  1  registered one-cycle terminal-count (carry/borrow) pulse.
- step  out  1  registered one-cycle pulse marking each count step (prescaler output).

Behaviour:
- Reset: on an rst_n=0 clock edge, count=0, tc=0, step=0 and the prescaler=0. Reset overrides all other inputs and is taken mid-operation with no delay.
- Priority per edge: rst_n > clear > load > step.
- Clear: count<=0, prescaler<=0, tc<=0, step<=0.
- Load: count<=load_val, but a load_val >= MODULUS is clamped to MODULUS-1. Prescaler<=0, tc<=0, step<=0.
- Prescaler:
  - Internal counter p in 0..PRESCALE-1. It advances only when en=1.
  - A step fires on an en=1 cycle with p==PRESCALE-1, and p then returns to 0.
  - en=0 freezes both p and count.
- Step, up=1:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1: wrap to 0 (SATURATE=0) or hold (SATURATE=1).
- Step, up=0:
  - count>0: count-1.
  - count==0: wrap to MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
- tc:
  - Asserted for exactly one cycle, on the edge where a step occurs with count at the terminal for the current direction (MODULUS-1 when up, 0 when down).
  - It is visible in the same cycle that count shows the wrapped value, or the held value when saturating.
  - In saturate mode tc pulses on every blocked step.
- step output mirrors the internal step event with the same registered timing as the count update.
- Latency: one clk from the qualifying input edge to the count/tc/step update; no combinational path from inputs to outputs.
- A direction change takes effect on the next step; the prescaler phase is not reset.
- Simultaneous clear+load: clear wins. Load+step: load wins and the step is discarded (no tc).
- Arithmetic is unsigned WIDTH-bit; internal compares use constants sized to WIDTH. No X is allowed to propagate from load_val unless load=1.

Decomposition:
- Package ctr_pkg holds:
  - the direction constants DIR_UP=1, DIR_DOWN=0;
  - a clog2 function for sizing the prescaler register;
  - the parameter-legality check, applied as an elaboration-time error for MODULUS > 2**WIDTH, MODULUS < 2 or PRESCALE < 1.
- One sub-module, ctr_prescaler:
  - parameter PRESCALE; ports clk, rst_n, en, restart, tick;
  - tick is combinational, one clk wide;
  - the top level registers it into the step output.

Test Plan:
- Reset then en=1, up=1, WIDTH=4, MODULUS=10, PRESCALE=1: count runs 0,1..9,0. tc=1 only in the cycle count returns to 0; step=1 every cycle.
- up=0 from 0 with the same parameters: count runs 9,8..0,9. tc pulses on the 0->9 transition.
- PRESCALE=4, en=1 for 12 cycles: exactly 3 steps, count=3. Toggle en=0 mid-run for 5 cycles: count and prescaler phase frozen, total steps unchanged.
- SATURATE=1, up=1, run to 9 then 3 more steps: count stays 9, tc pulses 3 times.
- load=1, load_val=4'hC with MODULUS=10: count=9. load=1 with clear=1 and load_val=5: count=0. load while step due: count=load_val, tc=0, prescaler restarts from 0.
- rst_n=0 asserted mid-count at value 6: next edge count=0, tc=0, step=0. With rst_n=0 and clk not toggling, outputs unchanged (synchronous reset only).

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encoding,
// sizing helpers and the parameter-legality rule.
package ctr_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A register always needs at least one bit, even for a divide-by-1.
  function automatic int prescale_width(input int prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

  function automatic bit params_ok(input int width, input int modulus, input int prescale);
    return (modulus >= 2) && (prescale >= 1) &&
           (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/ctr_prescaler.sv
// Clock-enable prescaler: tick is high for one enabled cycle out of every
// PRESCALE enabled cycles. The phase freezes while en is low.
module ctr_prescaler
  import ctr_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en & (phase == LAST);

  // NOTE: sequential state uses non-blocking <= so every flop samples
  // pre-edge values; rst_n is checked inside the clocked block, so reset is
  // synchronous and only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/ctr_mod_updown.sv
// Modulo-MODULUS up/down counter with prescaled clock enable, clear, load,
// wrap/saturate ends and registered tc/step pulses for cascading digits.
module ctr_mod_updown
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             step
);

  generate
    if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
      $error("ctr_mod_updown: illegal parameters (need 2 <= MODULUS <= 2**WIDTH, PRESCALE >= 1)");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam bit               SAT     = (SATURATE != 0);

  logic             tick;
  dir_e             dir;
  logic             at_term;
  logic [WIDTH-1:0] count_stepped;
  logic [WIDTH-1:0] load_clamped;

  ctr_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (clear | load),
    .tick    (tick)
  );

  assign dir = dir_e'(up);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    at_term       = 1'b0;
    count_stepped = count;
    if (dir == DIR_UP) begin
      at_term = (count == MAX_VAL);
      if (!at_term) begin
        count_stepped = count + WIDTH'(1);
      end else if (!SAT) begin
        count_stepped = ZERO;
      end
    end else begin
      at_term = (count == ZERO);
      if (!at_term) begin
        count_stepped = count - WIDTH'(1);
      end else if (!SAT) begin
        count_stepped = MAX_VAL;
      end
    end
  end

  // Out-of-range load values pin to the top of the count range; load_val is
  // only consumed on the load branch, so an idle bus cannot leak X.
  always_comb begin
    load_clamped = load_val;
    if (load_val > MAX_VAL) begin
      load_clamped = MAX_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= ZERO;
      tc    <= 1'b0;
      step  <= 1'b0;
    end else if (clear) begin
      count <= ZERO;
      tc    <= 1'b0;
      step  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      step  <= 1'b0;
    end else begin
      step <= tick;
      tc   <= tick & at_term;
      if (tick) begin
        count <= count_stepped;
      end
    end
  end

endmodule

// File: tb/tb_ctr_mod_updown.sv
// Self-checking bench: four parameterisations driven from shared inputs,
// a vector table, directed corner sequences and randomized traffic.
module tb_ctr_mod_updown;

  localparam int NI = 4;
  // Per-instance parameters, mirrored into the reference model.
  localparam int MOD_P[NI] = '{10, 10, 10, 16};
  localparam int PRE_P[NI] = '{1, 4, 1, 3};
  localparam int SAT_P[NI] = '{0, 0, 1, 1};

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt [NI];
  logic       tcv [NI];
  logic       stv [NI];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int mc [NI];
  int mp [NI];
  int mtc[NI];
  int mst[NI];

  always #5 if (clk_run) clk = ~clk;

  ctr_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt[0]), .tc(tcv[0]), .step(stv[0]));
  ctr_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt[1]), .tc(tcv[1]), .step(stv[1]));
  ctr_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt[2]), .tc(tcv[2]), .step(stv[2]));
  ctr_mod_updown #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SATURATE(1)) d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt[3]), .tc(tcv[3]), .step(stv[3]));

  typedef struct {
    logic       rst_n, en, up, clear, load;
    logic [3:0] lv;
    int         exp_cnt;
    logic       exp_tc, exp_st;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic c,
                     input logic l, input logic [3:0] v, input int ec,
                     input logic et, input logic es);
    vec_t t;
    t.rst_n = r; t.en = e; t.up = u; t.clear = c; t.load = l; t.lv = v;
    t.exp_cnt = ec; t.exp_tc = et; t.exp_st = es;
    tbl.push_back(t);
  endtask

  // Behavioural model: counts as integers with modulo arithmetic.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n || clear) begin
        mc[i] = 0; mp[i] = 0; mtc[i] = 0; mst[i] = 0;
      end else if (load) begin
        mc[i] = (int'(load_val) >= MOD_P[i]) ? MOD_P[i] - 1 : int'(load_val);
        mp[i] = 0; mtc[i] = 0; mst[i] = 0;
      end else begin
        int  nxt;
        bit  fire;
        fire   = en && (mp[i] == PRE_P[i] - 1);
        mtc[i] = 0;
        mst[i] = fire;
        if (en) mp[i] = (mp[i] + 1) % PRE_P[i];
        if (fire) begin
          nxt = up ? mc[i] + 1 : mc[i] - 1;
          if (nxt < 0 || nxt >= MOD_P[i]) begin
            mtc[i] = 1;
            if (SAT_P[i] == 0) mc[i] = (nxt + MOD_P[i]) % MOD_P[i];
          end else begin
            mc[i] = nxt;
          end
        end
      end
    end
  endtask

  int n_step1 = 0;
  int n_tc2   = 0;

  // One clock: edge, model update, sample 1 ns later, compare every instance.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    if (stv[1] === 1'b1) n_step1++;
    if (tcv[2] === 1'b1) n_tc2++;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model d%0d.count", i), 32'(cnt[i]), 32'(mc[i]));
      check($sformatf("model d%0d.tc", i),    32'(tcv[i]), 32'(mtc[i]));
      check($sformatf("model d%0d.step", i),  32'(stv[i]), 32'(mst[i]));
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic c,
                       input logic l, input logic [3:0] v);
    rst_n = r; en = e; up = u; clear = c; load = l; load_val = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      mc[i] = 0; mp[i] = 0; mtc[i] = 0; mst[i] = 0;
    end

    // ---- vector table, checked against d0 (MOD 10, PRESCALE 1, wrap) ----
    add(0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(1, 1, 1, 0, 0, 4'd0, k % 10, k == 10, 1);
    for (int k = 1; k <= 11; k++)
      add(1, 1, 0, 0, 0, 4'd0, (10 - k % 10) % 10, (k == 1) || (k == 11), 1);
    add(1, 0, 1, 0, 1, 4'hC, 9, 0, 0);   // clamp
    add(1, 1, 1, 1, 1, 4'd5, 0, 0, 0);   // clear beats load
    add(1, 1, 1, 0, 1, 4'd7, 7, 0, 0);   // load beats a due step
    add(1, 1, 1, 0, 0, 4'd0, 8, 0, 1);
    add(1, 1, 1, 0, 1, 4'd9, 9, 0, 0);
    add(1, 1, 1, 0, 0, 4'd0, 0, 1, 1);

    foreach (tbl[j]) begin
      drive(tbl[j].rst_n, tbl[j].en, tbl[j].up, tbl[j].clear, tbl[j].load, tbl[j].lv);
      cycle();
      check($sformatf("vec%0d count", j), 32'(cnt[0]), 32'(tbl[j].exp_cnt));
      check($sformatf("vec%0d tc", j),    32'(tcv[0]), 32'(tbl[j].exp_tc));
      check($sformatf("vec%0d step", j),  32'(stv[0]), 32'(tbl[j].exp_st));
    end

    // ---- prescaler and saturation from a fresh reset ----
    drive(0, 0, 1, 0, 0, 4'd0);
    cycle();
    n_step1 = 0;
    n_tc2   = 0;
    drive(1, 1, 1, 0, 0, 4'd0);
    for (int k = 0; k < 9; k++) cycle();
    check("sat reach 9", 32'(cnt[2]), 32'd9);
    for (int k = 0; k < 3; k++) cycle();
    check("sat held at 9", 32'(cnt[2]), 32'd9);
    check("sat tc pulses", 32'(n_tc2), 32'd3);
    check("pre4 steps after 12", 32'(n_step1), 32'd3);
    check("pre4 count after 12", 32'(cnt[1]), 32'd3);

    for (int k = 0; k < 2; k++) cycle();          // phase advances to 2
    drive(1, 0, 1, 0, 0, 4'd0);
    for (int k = 0; k < 5; k++) cycle();          // frozen
    check("pre4 frozen count", 32'(cnt[1]), 32'd3);
    check("pre4 frozen steps", 32'(n_step1), 32'd3);
    drive(1, 1, 1, 0, 0, 4'd0);
    cycle();                                      // phase 3, no step yet
    check("pre4 phase kept", 32'(cnt[1]), 32'd3);
    cycle();
    check("pre4 resumed step", 32'(cnt[1]), 32'd4);

    // ---- load while a prescaled step is due ----
    for (int k = 0; k < 3; k++) cycle();          // phase 3
    drive(1, 1, 1, 0, 1, 4'd5);
    cycle();
    check("pre4 load count", 32'(cnt[1]), 32'd5);
    check("pre4 load tc", 32'(tcv[1]), 32'd0);
    check("pre4 load step", 32'(stv[1]), 32'd0);
    drive(1, 1, 1, 0, 0, 4'd0);
    for (int k = 0; k < 3; k++) cycle();
    check("pre4 restart hold", 32'(cnt[1]), 32'd5);
    cycle();
    check("pre4 restart step", 32'(cnt[1]), 32'd6);

    // ---- synchronous reset mid-count, including a stopped clock ----
    drive(1, 0, 1, 0, 1, 4'd5);
    cycle();
    drive(1, 1, 1, 0, 0, 4'd0);
    cycle();
    check("d0 at 6", 32'(cnt[0]), 32'd6);
    clk_run = 1'b0;
    rst_n   = 1'b0;
    #40;
    check("no clk reset count", 32'(cnt[0]), 32'd6);
    check("no clk reset step", 32'(stv[0]), 32'd1);
    clk_run = 1'b1;
    cycle();
    check("reset count", 32'(cnt[0]), 32'd0);
    check("reset tc", 32'(tcv[0]), 32'd0);
    check("reset step", 32'(stv[0]), 32'd0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 99) != 0,
            ($urandom % 4) != 0,
            ($urandom_range(0, 15) == 0) ? ~up : up,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 24) == 0,
            4'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
